// File: rtl/loopback_inc_engine.sv
`timescale 1ns/1ps
// loopback_inc_engine: returns v+1 with the request tag echoed, through a
// one-entry stage register feeding a response FIFO. Requests are only
// accepted while stage + FIFO occupancy leaves a free slot, so the
// stage-to-FIFO push never needs to stall.
module loopback_inc_engine #(
  parameter int WIDTH    = 32,
  parameter int ID_WIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    req_data,
  input  logic [ID_WIDTH-1:0] req_id,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic                rsp_ovf,
  output logic                busy,
  output logic [15:0]         count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  logic                s1_valid;
  logic [WIDTH-1:0]    s1_data;
  logic [ID_WIDTH-1:0] s1_id;
  logic                s1_ovf;

  logic [WIDTH-1:0]    mem_data [DEPTH];
  logic [ID_WIDTH-1:0] mem_id   [DEPTH];
  logic                mem_ovf  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;

  logic accept;
  logic push;
  logic pop;

  // Credit check looks only at local state, never at rsp_ready.
  assign occupancy = fifo_count + CW'(s1_valid);
  assign req_ready = reset_n && (occupancy < DEPTH_C);
  assign accept    = req_valid && req_ready;
  assign push      = s1_valid;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = s1_valid || (fifo_count != '0);

  // Head fields are forced to zero when the FIFO is empty so that stale
  // memory contents never show (including during reset).
  assign rsp_data = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_id   = rsp_valid ? mem_id[rd_ptr]   : '0;
  assign rsp_ovf  = rsp_valid ? mem_ovf[rd_ptr]  : 1'b0;

  // Stage 1: compute v+1 and the signed-overflow flag for each accepted request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      s1_ovf   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= req_data + WIDTH'(1);
        s1_id   <= req_id;
        s1_ovf  <= (req_data == MAX_POS);
      end
    end
  end

  // FIFO storage: written from stage 1 whenever it holds an entry.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= s1_data;
      mem_id[wr_ptr]   <= s1_id;
      mem_ovf[wr_ptr]  <= s1_ovf;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Delivered-response counter, saturating at all ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (pop && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule
